alu_arbiter: RTL and testbench

//  Shares one combinational 32-bit ALU (3-bit command: ADD/SUB/XOR/SLT/AND/NAND/NOR/OR)

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side signals of the shared-ALU arbiter.
// The slave modport is the arbiter itself; the master modport is the surrounding system.
`default_nettype none

interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CMDW  = 3
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [CMDW-1:0]  req0_cmd;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CMDW-1:0]  req1_cmd;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_ovf;

  logic [CMDW-1:0]  alu_cmd;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_ovf;

  modport slave (
    input  req_valid, req0_cmd, req0_a, req0_b, req1_cmd, req1_a, req1_b,
    output req_ready,
    output rsp_valid, rsp_result, rsp_zero, rsp_ovf,
    input  rsp_ready,
    output alu_cmd, alu_a, alu_b,
    input  alu_result, alu_zero, alu_ovf
  );

  modport master (
    output req_valid, req0_cmd, req0_a, req0_b, req1_cmd, req1_a, req1_b,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_zero, rsp_ovf,
    output rsp_ready,
    input  alu_cmd, alu_a, alu_b,
    output alu_result, alu_zero, alu_ovf
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Optional feature macro ALU_ARB_PERF_EN adds saturating per-requester response counters.
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CMDW  = 3,
  parameter int CNTW  = 16
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  alu_arbiter_if.slave   bus
`ifdef ALU_ARB_PERF_EN
  ,
  input  wire logic            perf_clr,
  output logic [CNTW-1:0]      perf_cnt0,
  output logic [CNTW-1:0]      perf_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  if (CNTW < 1 || WIDTH < 2 || CMDW < 1) begin : g_param_check
    $error("alu_arbiter: illegal parameter values");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr_ptr;
  logic             r_gnt;
  logic [CMDW-1:0]  r_alu_cmd;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_ovf;

  logic             w_gnt;
  logic             w_req_hs;
  logic             w_rsp_hs;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_rsp_valid;

  // Round-robin pointer only breaks ties; a lone requester is always granted.
  always_comb begin
    w_gnt = 1'b0;
    if (&bus.req_valid) begin
      w_gnt = r_rr_ptr;
    end else if (bus.req_valid[1]) begin
      w_gnt = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_hs    = 1'b0;
    w_rsp_hs    = 1'b0;
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          w_req_hs    = 1'b1;
          w_req_ready = w_gnt ? 2'b10 : 2'b01;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = r_gnt ? 2'b10 : 2'b01;
        if (bus.rsp_ready[r_gnt]) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr     <= 1'b0;
      r_gnt        <= 1'b0;
      r_alu_cmd    <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_gnt     <= w_gnt;
        r_alu_cmd <= w_gnt ? bus.req1_cmd : bus.req0_cmd;
        r_alu_a   <= w_gnt ? bus.req1_a   : bus.req0_a;
        r_alu_b   <= w_gnt ? bus.req1_b   : bus.req0_b;
      end
      // ALU operands have been stable for a full cycle by the end of EXEC.
      if (r_state == S_EXEC) begin
        r_rsp_result <= bus.alu_result;
        r_rsp_zero   <= bus.alu_zero;
        r_rsp_ovf    <= bus.alu_ovf;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= ~r_gnt;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [CNTW-1:0] r_cnt0;
  logic [CNTW-1:0] r_cnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (perf_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_rsp_hs) begin
      if (!r_gnt && (r_cnt0 != '1)) begin
        r_cnt0 <= r_cnt0 + CNTW'(1);
      end
      if (r_gnt && (r_cnt1 != '1)) begin
        r_cnt1 <= r_cnt1 + CNTW'(1);
      end
    end
  end

  assign perf_cnt0 = r_cnt0;
  assign perf_cnt1 = r_cnt1;
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_ovf    = r_rsp_ovf;
  assign bus.alu_cmd    = r_alu_cmd;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus hand-written multi-cycle sequences,
// with a behavioural ALU attached to the arbiter's ALU port.
`default_nettype none

module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int CMDW  = 3;
  localparam int CNTW  = 3;

  localparam logic [2:0] C_ADD  = 3'd0;
  localparam logic [2:0] C_SUB  = 3'd1;
  localparam logic [2:0] C_XOR  = 3'd2;
  localparam logic [2:0] C_SLT  = 3'd3;
  localparam logic [2:0] C_AND  = 3'd4;
  localparam logic [2:0] C_NAND = 3'd5;
  localparam logic [2:0] C_NOR  = 3'd6;
  localparam logic [2:0] C_OR   = 3'd7;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_fail;

  alu_arbiter_if #(.WIDTH(WIDTH), .CMDW(CMDW)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic            perf_clr;
  logic [CNTW-1:0] perf_cnt0;
  logic [CNTW-1:0] perf_cnt1;

  alu_arbiter #(.WIDTH(WIDTH), .CMDW(CMDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .perf_clr  (perf_clr),
    .perf_cnt0 (perf_cnt0),
    .perf_cnt1 (perf_cnt1)
  );
`else
  alu_arbiter #(.WIDTH(WIDTH), .CMDW(CMDW), .CNTW(CNTW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
`endif

  // Reference ALU: the shared combinational unit the arbiter drives.
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  always_comb begin
    w_sum          = bus.alu_a + bus.alu_b;
    w_dif          = bus.alu_a - bus.alu_b;
    bus.alu_result = '0;
    bus.alu_ovf    = 1'b0;
    case (bus.alu_cmd)
      C_ADD: begin
        bus.alu_result = w_sum;
        bus.alu_ovf    = (bus.alu_a[31] == bus.alu_b[31]) && (w_sum[31] != bus.alu_a[31]);
      end
      C_SUB: begin
        bus.alu_result = w_dif;
        bus.alu_ovf    = (bus.alu_a[31] != bus.alu_b[31]) && (w_dif[31] != bus.alu_a[31]);
      end
      C_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      C_SLT:  bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      C_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      C_NAND: bus.alu_result = ~(bus.alu_a & bus.alu_b);
      C_NOR:  bus.alu_result = ~(bus.alu_a | bus.alu_b);
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          who;
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic [2:0] cmd,
                         input logic [31:0] a, input logic [31:0] b);
    if (who == 0) begin
      bus.req0_cmd = cmd; bus.req0_a = a; bus.req0_b = b;
      bus.req_valid[0] = 1'b1;
    end else begin
      bus.req1_cmd = cmd; bus.req1_a = a; bus.req1_b = b;
      bus.req_valid[1] = 1'b1;
    end
  endtask

  task automatic do_reset();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
  endtask

  // Single uncontended operation: accept, EXEC, RESP, handshake.
  task automatic do_op(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = (v.who == 0) ? 2'b01 : 2'b10;
    set_req(v.who, v.cmd, v.a, v.b);
    #1;
    check($sformatf("v%0d accept_ready", idx), {30'd0, bus.req_ready}, {30'd0, oh});
    tick();
    bus.req_valid = 2'b00;
    #1;
    check($sformatf("v%0d exec_ready", idx), {30'd0, bus.req_ready}, 32'd0);
    check($sformatf("v%0d exec_rsp_valid", idx), {30'd0, bus.rsp_valid}, 32'd0);
    check($sformatf("v%0d alu_a", idx), bus.alu_a, v.a);
    check($sformatf("v%0d alu_b", idx), bus.alu_b, v.b);
    check($sformatf("v%0d alu_cmd", idx), {29'd0, bus.alu_cmd}, {29'd0, v.cmd});
    tick();
    check($sformatf("v%0d rsp_valid", idx), {30'd0, bus.rsp_valid}, {30'd0, oh});
    check($sformatf("v%0d result", idx), bus.rsp_result, v.res);
    check($sformatf("v%0d zero", idx), {31'd0, bus.rsp_zero}, {31'd0, v.z});
    check($sformatf("v%0d ovf", idx), {31'd0, bus.rsp_ovf}, {31'd0, v.o});
    bus.rsp_ready = oh;
    tick();
    bus.rsp_ready = 2'b00;
    check($sformatf("v%0d rsp_drop", idx), {30'd0, bus.rsp_valid}, 32'd0);
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic check_perf(input string name, input int c0, input int c1);
    check({name, " perf_cnt0"}, {29'd0, perf_cnt0}, c0);
    check({name, " perf_cnt1"}, {29'd0, perf_cnt1}, c1);
  endtask
`endif

  initial begin
    n_vec  = 0;
    n_fail = 0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req0_cmd = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_cmd = '0; bus.req1_a = '0; bus.req1_b = '0;
`ifdef ALU_ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    vt[0]  = '{0, C_ADD,  32'd21,        32'd21,        32'd42,        1'b0, 1'b0};
    vt[1]  = '{1, C_ADD,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vt[2]  = '{0, C_XOR,  32'hF,         32'hF,         32'h0,         1'b1, 1'b0};
    vt[3]  = '{1, C_SUB,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1};
    vt[4]  = '{0, C_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0};
    vt[5]  = '{0, C_SLT,  32'd5,         32'd3,         32'd0,         1'b1, 1'b0};
    vt[6]  = '{1, C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vt[7]  = '{0, C_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0};
    vt[8]  = '{0, C_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[9]  = '{1, C_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
    vt[10] = '{0, C_SUB,  32'd5,         32'd5,         32'h0,         1'b1, 1'b0};
    vt[11] = '{0, C_OR,   32'h0,         32'h0,         32'h0,         1'b1, 1'b0};

    // Reset values, observed while reset is held and before any clock edge.
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("rst alu_a", bus.alu_a, 32'd0);
    check("rst alu_b", bus.alu_b, 32'd0);
    check("rst alu_cmd", {29'd0, bus.alu_cmd}, 32'd0);
    check("rst rsp_result", bus.rsp_result, 32'd0);
    check("rst rsp_flags", {30'd0, bus.rsp_zero, bus.rsp_ovf}, 32'd0);
`ifdef ALU_ARB_PERF_EN
    check_perf("rst", 0, 0);
`endif
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_op(vt[i], i);
    end
`ifdef ALU_ARB_PERF_EN
    check_perf("table saturate", 7, 4);
`endif

    // Contention right after reset: requester 0 first, then requester 1.
    do_reset();
    set_req(0, C_SUB, 32'd1000, 32'd998);
    set_req(1, C_SUB, 32'd1111, 32'd1112);
    #1;
    check("cont first_grant", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b10;
    #1;
    check("cont exec_ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    check("cont rsp0_valid", {30'd0, bus.rsp_valid}, 32'd1);
    check("cont rsp0_result", bus.rsp_result, 32'd2);
    bus.rsp_ready = 2'b10;
    tick();
    check("cont wrong_rdy_ignored", {30'd0, bus.rsp_valid}, 32'd1);
    check("cont resp_ready_blocked", {30'd0, bus.req_ready}, 32'd0);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    check("cont rsp0_drop", {30'd0, bus.rsp_valid}, 32'd0);
    check("cont second_grant", {30'd0, bus.req_ready}, 32'd2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("cont rsp1_valid", {30'd0, bus.rsp_valid}, 32'd2);
    check("cont rsp1_result", bus.rsp_result, 32'hFFFF_FFFF);
    check("cont rsp1_ovf", {31'd0, bus.rsp_ovf}, 32'd0);
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;
    check("cont rsp1_drop", {30'd0, bus.rsp_valid}, 32'd0);
`ifdef ALU_ARB_PERF_EN
    check_perf("cont", 1, 1);
    perf_clr = 1'b1;
    bus.rsp_ready = 2'b00;
    tick();
    perf_clr = 1'b0;
    check_perf("clear", 0, 0);
`endif

    // Fairness: both continuously valid; the first grant also shows rr_ptr back at 0.
    set_req(0, C_ADD, 32'd1, 32'd2);
    set_req(1, C_OR, 32'hF0, 32'h0F);
    bus.rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] oh;
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("fair%0d grant", k), {30'd0, bus.req_ready}, {30'd0, oh});
      tick();
      check($sformatf("fair%0d exec_ready", k), {30'd0, bus.req_ready}, 32'd0);
      tick();
      check($sformatf("fair%0d rsp_valid", k), {30'd0, bus.rsp_valid}, {30'd0, oh});
      check($sformatf("fair%0d result", k), bus.rsp_result, (k % 2 == 0) ? 32'd3 : 32'hFF);
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
`ifdef ALU_ARB_PERF_EN
    check_perf("fair", 3, 3);
`endif

    // Backpressure: response held 5 cycles, requester 1 waits for the handshake.
    set_req(0, C_SLT, 32'd3, 32'd15);
    #1;
    check("bp accept", {30'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    set_req(1, C_ADD, 32'd100, 32'd23);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d rsp_valid", k), {30'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("bp%0d result", k), bus.rsp_result, 32'd1);
      check($sformatf("bp%0d req1_blocked", k), {30'd0, bus.req_ready}, 32'd0);
      tick();
    end
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    check("bp rsp_drop", {30'd0, bus.rsp_valid}, 32'd0);
    check("bp req1_grant", {30'd0, bus.req_ready}, 32'd2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("bp req1_rsp", {30'd0, bus.rsp_valid}, 32'd2);
    check("bp req1_result", bus.rsp_result, 32'd123);
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;

    // Reset during EXEC: outputs clear without a clock edge, no response afterwards.
    set_req(0, C_ADD, 32'h55, 32'h11);
    tick();
    bus.req_valid = 2'b00;
    #2 reset_n = 1'b0;
    #1;
    check("rstmid rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("rstmid req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rstmid alu_a", bus.alu_a, 32'd0);
    check("rstmid alu_b", bus.alu_b, 32'd0);
    check("rstmid rsp_result", bus.rsp_result, 32'd0);
`ifdef ALU_ARB_PERF_EN
    check_perf("rstmid", 0, 0);
`endif
    #3 reset_n = 1'b1;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rstmid post%0d rsp_valid", k), {30'd0, bus.rsp_valid}, 32'd0);
    end
    bus.rsp_ready = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
